gat_bram_host_bridge: RTL and testbench
=======================================

Name: gat_bram_host_bridge

Overview:
Parametrised host-to-accelerator bridge that generalises the GAT top wrapper's per-BRAM byte-address slicing to NUM_CH load channels. It counts writes per channel against a programmed depth and raises load-done itself, sequences the layer start/ready handshake with the GAT core, and serves pipelined feature readback. It sits between the PS/AXI BRAM controllers and gat_top.

Parameters:
NUM_CH, 3, number of host load channels (H data, node info, weight by default)
TOP_WIDTH, 32, host data width
ADDR_W, 18, word-address width of each load BRAM
FEAT_ADDR_W, 16, word-address width of the feature BRAM
RD_LAT, 2, feature BRAM read latency in cycles (1..4)

Ports:
clk  in  1  clock
rst  in  1  async reset, active-high
cfg_depth  in  NUM_CH*(ADDR_W+1)  expected word count per channel; sampled in IDLE
clear  in  1  return to IDLE, clear counters and sticky flags
wr_en  in  1  host write strobe
wr_ch  in  $clog2(NUM_CH)  target channel
wr_addr  in  ADDR_W+2  byte address
wr_data  in  TOP_WIDTH  write data
wr_ready  out  1  write accepted this cycle
bram_ena  out  NUM_CH  per-channel enable
bram_wea  out  NUM_CH  per-channel write enable
bram_addra  out  NUM_CH*ADDR_W  word address per channel
bram_din  out  TOP_WIDTH  shared write data
load_done  out  NUM_CH  per-channel load complete
core_start  out  1  one-cycle start pulse to core
core_ready  in  1  core finished layer
rd_req  in  1  host read request
rd_addr  in  FEAT_ADDR_W+2  byte address
feat_bram_addrb  out  FEAT_ADDR_W  feature BRAM word address
feat_bram_dout  in  TOP_WIDTH  feature BRAM data
rd_valid  out  1  read data valid
rd_data  out  TOP_WIDTH  read data
err  out  3  sticky {rd_while_busy, addr_oob, wr_while_busy}
state  out  3  FSM state for debug

Behaviour:
- Reset: all outputs 0; state=IDLE; counters, depth latches, flags 0.
- Address: word address = byte address[ADDR_W+1:2]; low two bits ignored.
- FSM states: IDLE(0), LOAD(1), ARM(2), BUSY(3), DONE(4).
- IDLE: latch cfg_depth each cycle; first accepted wr_en -> LOAD (that write is performed).
- LOAD: wr_ready=1. Write registered: bram_ena/wea[wr_ch], bram_addra slice, bram_din driven one cycle after wr_en. Channel count increments per accepted write; load_done[ch] set when count == depth[ch], and stays set.
- Address >= depth[ch] or wr_ch >= NUM_CH: write dropped (no BRAM strobe, no count), err[1] set.
- Channel with depth 0: load_done set on entry to LOAD.
- All load_done set -> ARM; ARM asserts core_start exactly one cycle -> BUSY.
- BUSY: wr_ready=0; wr_en sets err[0], dropped. core_ready high -> DONE (no earlier than 1 cycle after core_start).
- DONE: reads served; new wr_en -> LOAD with counters cleared (next layer), load_done cleared same cycle.
- Read: rd_req in DONE drives feat_bram_addrb next cycle; rd_valid/rd_data asserted exactly RD_LAT+1 cycles after rd_req; back-to-back rd_req every cycle fully pipelined. rd_req outside DONE: rd_valid at same latency with rd_data=0, err[2] set.
- clear: highest priority after reset; any state -> IDLE next cycle; in-flight reads still complete.
- rst mid-operation: immediate return to reset values, pending read pipeline discarded.
- Counters width ADDR_W+1; saturate, no wrap.

Optional Feature:
GAT_BRIDGE_CKSUM_EN: when defined, per-channel 32-bit running additive checksum (mod 2^32) of accepted write data, exposed on extra output cksum (NUM_CH*32), cleared with counters. Undefined: port absent, no logic.

Test Plan:
- depth={4,2,3}, 9 in-range writes interleaved -> load_done 3'b111 after last write, core_start single pulse 2 cycles later, state=BUSY.
- ch1 write at byte addr 0x10 (word 4) with depth 2 -> no bram_wea, err=3'b010, count unchanged.
- core_ready in DONE, rd_req addr 0x0C, RD_LAT=2, feat dout 0xDEADBEEF -> feat_bram_addrb=3, rd_valid 3 cycles after req with 0xDEADBEEF.
- rd_req during BUSY -> rd_valid at latency with rd_data=0, err[2]=1.
- wr_en during BUSY -> wr_ready=0, err[0]=1; clear -> IDLE, err=0, load_done=0.
- With GAT_BRIDGE_CKSUM_EN: ch0 writes 1,2,0xFFFFFFFF -> cksum[31:0]=2.

Source files
------------

// File: rtl/gat_bram_host_bridge.sv
// Host-to-GAT bridge: per-channel BRAM load with depth tracking, layer start/ready handshake, pipelined feature readback.
// Optional build macro GAT_BRIDGE_CKSUM_EN adds per-channel running write checksums on cksum.
module gat_bram_host_bridge #(
   parameter int NUM_CH      = 3,
   parameter int TOP_WIDTH   = 32,
   parameter int ADDR_W      = 18,
   parameter int FEAT_ADDR_W = 16,
   parameter int RD_LAT      = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH*(ADDR_W+1)-1:0]  cfg_depth,
   input  logic                          clear,
   input  logic                          wr_en,
   input  logic [CH_W-1:0]               wr_ch,
   input  logic [ADDR_W+1:0]             wr_addr,
   input  logic [TOP_WIDTH-1:0]          wr_data,
   output logic                          wr_ready,
   output logic [NUM_CH-1:0]             bram_ena,
   output logic [NUM_CH-1:0]             bram_wea,
   output logic [NUM_CH*ADDR_W-1:0]      bram_addra,
   output logic [TOP_WIDTH-1:0]          bram_din,
   output logic [NUM_CH-1:0]             load_done,
   output logic                          core_start,
   input  logic                          core_ready,
   input  logic                          rd_req,
   input  logic [FEAT_ADDR_W+1:0]        rd_addr,
   output logic [FEAT_ADDR_W-1:0]        feat_bram_addrb,
   input  logic [TOP_WIDTH-1:0]          feat_bram_dout,
   output logic                          rd_valid,
   output logic [TOP_WIDTH-1:0]          rd_data,
   output logic [2:0]                    err,
`ifdef GAT_BRIDGE_CKSUM_EN
   output logic [NUM_CH*32-1:0]          cksum,
`endif
   output logic [2:0]                    state
);

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ARM  = 3'd2,
      S_BUSY = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            st;
   logic [CNT_W-1:0]  depth_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_q     [NUM_CH];
   logic [CNT_W-1:0]  depth_eff [NUM_CH];
   logic [CNT_W-1:0]  cnt_nxt   [NUM_CH];
   logic [NUM_CH-1:0] hit_vec;
   logic [NUM_CH-1:0] done_nxt;
   logic              wr_take;
   logic              wr_bad;
   logic              wr_blocked;
   logic              rd_ok;
   logic [ADDR_W-1:0] wr_word;
   logic [RD_LAT:0]   rd_vld_p;
   logic [RD_LAT:0]   rd_ok_p;
   logic              unused_addr_lsbs;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != '1))
         return v + CNT_W'(1);
      return v;
   endfunction

   assign wr_word          = wr_addr[ADDR_W+1:2];
   assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};
   assign state            = st;
   assign wr_blocked       = wr_en && ((st == S_ARM) || (st == S_BUSY));
   assign rd_ok            = rd_req && (st == S_DONE);

   // IDLE compares against the live depth so the very first write sees the value being latched.
   always_comb begin
      wr_take  = wr_en && wr_ready;
      hit_vec  = '0;
      done_nxt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         depth_eff[c] = (st == S_IDLE) ? cfg_depth[c*CNT_W +: CNT_W] : depth_q[c];
         hit_vec[c]   = wr_take && (int'(wr_ch) == c) && ({1'b0, wr_word} < depth_eff[c]);
         cnt_nxt[c]   = sat_inc((st == S_LOAD) ? cnt_q[c] : '0, hit_vec[c]);
         done_nxt[c]  = (cnt_nxt[c] == depth_eff[c]);
      end
      wr_bad = wr_take && (hit_vec == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= S_IDLE;
         wr_ready   <= 1'b0;
         core_start <= 1'b0;
         load_done  <= '0;
         err        <= '0;
         bram_ena   <= '0;
         bram_wea   <= '0;
         bram_addra <= '0;
         bram_din   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            depth_q[c] <= '0;
            cnt_q[c]   <= '0;
         end
      end else if (clear) begin
         st         <= S_IDLE;
         wr_ready   <= 1'b1;
         core_start <= 1'b0;
         load_done  <= '0;
         err        <= '0;
         bram_ena   <= '0;
         bram_wea   <= '0;
         for (int c = 0; c < NUM_CH; c++)
            cnt_q[c] <= '0;
      end else begin
         bram_ena   <= hit_vec;
         bram_wea   <= hit_vec;
         core_start <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (hit_vec[c])
               bram_addra[c*ADDR_W +: ADDR_W] <= wr_word;
            if (st == S_IDLE)
               depth_q[c] <= depth_eff[c];
         end
         if (|hit_vec)
            bram_din <= wr_data;
         if (wr_blocked)
            err[0] <= 1'b1;
         if (wr_bad)
            err[1] <= 1'b1;
         if (rd_req && (st != S_DONE))
            err[2] <= 1'b1;
         case (st)
            S_IDLE, S_DONE: begin
               wr_ready <= 1'b1;
               if (wr_take) begin
                  st        <= S_LOAD;
                  load_done <= done_nxt;
                  for (int c = 0; c < NUM_CH; c++)
                     cnt_q[c] <= cnt_nxt[c];
               end
            end
            S_LOAD: begin
               load_done <= load_done | done_nxt;
               for (int c = 0; c < NUM_CH; c++)
                  cnt_q[c] <= cnt_nxt[c];
               if (&load_done) begin
                  st       <= S_ARM;
                  wr_ready <= 1'b0;
               end
            end
            S_ARM: begin
               core_start <= 1'b1;
               st         <= S_BUSY;
            end
            S_BUSY: begin
               // core_ready is not honoured in the same cycle as the start pulse.
               if (core_ready && !core_start) begin
                  st       <= S_DONE;
                  wr_ready <= 1'b1;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   // Read pipeline: stage p0 issues the BRAM address, stage p(RD_LAT+1) captures dout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_p        <= '0;
         rd_ok_p         <= '0;
         feat_bram_addrb <= '0;
         rd_valid        <= 1'b0;
         rd_data         <= '0;
      end else begin
         rd_vld_p <= {rd_vld_p[RD_LAT-1:0], rd_req};
         rd_ok_p  <= {rd_ok_p[RD_LAT-1:0], rd_ok};
         if (rd_ok)
            feat_bram_addrb <= rd_addr[FEAT_ADDR_W+1:2];
         rd_valid <= rd_vld_p[RD_LAT];
         rd_data  <= rd_ok_p[RD_LAT] ? feat_bram_dout : '0;
      end
   end

`ifdef GAT_BRIDGE_CKSUM_EN
   logic [31:0] ck_q [NUM_CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++)
            ck_q[c] <= '0;
      end else if (clear) begin
         for (int c = 0; c < NUM_CH; c++)
            ck_q[c] <= '0;
      end else if ((st == S_LOAD) || (((st == S_IDLE) || (st == S_DONE)) && wr_take)) begin
         for (int c = 0; c < NUM_CH; c++)
            ck_q[c] <= ((st == S_LOAD) ? ck_q[c] : 32'd0) + (hit_vec[c] ? 32'(wr_data) : 32'd0);
      end
   end

   always_comb begin
      cksum = '0;
      for (int c = 0; c < NUM_CH; c++)
         cksum[c*32 +: 32] = ck_q[c];
   end
`endif

endmodule

// File: tb/tb_gat_bram_host_bridge.sv
// Bench for gat_bram_host_bridge: randomized load/readback traffic checked against a transaction-level model.
module tb_gat_bram_host_bridge;
   localparam int NUM_CH      = 3;
   localparam int TOP_WIDTH   = 32;
   localparam int ADDR_W      = 18;
   localparam int FEAT_ADDR_W = 16;
   localparam int RD_LAT      = 2;
   localparam int CNT_W       = ADDR_W + 1;
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, ARM = 3'd2, BUSY = 3'd3, DONE = 3'd4;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic [NUM_CH*CNT_W-1:0]      cfg_depth = '0;
   logic                         clear = 1'b0;
   logic                         wr_en = 1'b0;
   logic [1:0]                   wr_ch = '0;
   logic [ADDR_W+1:0]            wr_addr = '0;
   logic [TOP_WIDTH-1:0]         wr_data = '0;
   logic                         wr_ready;
   logic [NUM_CH-1:0]            bram_ena, bram_wea;
   logic [NUM_CH*ADDR_W-1:0]     bram_addra;
   logic [TOP_WIDTH-1:0]         bram_din;
   logic [NUM_CH-1:0]            load_done;
   logic                         core_start;
   logic                         core_ready = 1'b0;
   logic                         rd_req = 1'b0;
   logic [FEAT_ADDR_W+1:0]       rd_addr = '0;
   logic [FEAT_ADDR_W-1:0]       feat_bram_addrb;
   logic [TOP_WIDTH-1:0]         feat_bram_dout;
   logic                         rd_valid;
   logic [TOP_WIDTH-1:0]         rd_data;
   logic [2:0]                   err;
   logic [2:0]                   state;
`ifdef GAT_BRIDGE_CKSUM_EN
   logic [NUM_CH*32-1:0]         cksum;
`endif

   gat_bram_host_bridge #(
      .NUM_CH(NUM_CH), .TOP_WIDTH(TOP_WIDTH), .ADDR_W(ADDR_W),
      .FEAT_ADDR_W(FEAT_ADDR_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .clear(clear),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_din(bram_din),
      .load_done(load_done), .core_start(core_start), .core_ready(core_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .feat_bram_addrb(feat_bram_addrb),
      .feat_bram_dout(feat_bram_dout), .rd_valid(rd_valid), .rd_data(rd_data),
      .err(err),
`ifdef GAT_BRIDGE_CKSUM_EN
      .cksum(cksum),
`endif
      .state(state)
   );

   always #5 clk = ~clk;

   // Feature BRAM: fixed contents, RD_LAT cycles from address to data.
   logic [31:0] feat_mem [256];
   logic [31:0] bram_pipe [RD_LAT];
   always @(posedge clk) begin
      bram_pipe[0] <= feat_mem[feat_bram_addrb[7:0]];
      for (int k = 1; k < RD_LAT; k++)
         bram_pipe[k] <= bram_pipe[k-1];
   end
   assign feat_bram_dout = bram_pipe[RD_LAT-1];

   int          n_vec = 0;
   int          n_mis = 0;
   int          cyc   = 0;
   logic [31:0] exp_rd [int];
   int          m_depth [NUM_CH];
   int          m_cnt   [NUM_CH];
   logic [31:0] m_ck    [NUM_CH];
   logic [NUM_CH-1:0] m_done;
   logic [2:0]  m_err;
   int          ops_ch[$];
   int          ops_w[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (exp_rd.exists(cyc)) begin
         chk("rd_valid", rd_valid, 1);
         chk("rd_data", rd_data, exp_rd[cyc]);
         exp_rd.delete(cyc);
      end else begin
         chk("rd_valid_quiet", rd_valid, 0);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = 0;
         m_ck[c]  = '0;
      end
      m_done = '0;
   endtask

   task automatic set_depths(input int d0, input int d1, input int d2);
      m_depth[0] = d0; m_depth[1] = d1; m_depth[2] = d2;
      for (int c = 0; c < NUM_CH; c++)
         cfg_depth[c*CNT_W +: CNT_W] = CNT_W'(m_depth[c]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, state, IDLE);
      chk({tag, "_wr_ready"}, wr_ready, 0);
      chk({tag, "_load_done"}, load_done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
      chk({tag, "_bram_wea"}, {bram_ena, bram_wea}, 0);
      chk({tag, "_bram_addra"}, bram_addra, 0);
      chk({tag, "_bram_din"}, bram_din, 0);
      chk({tag, "_addrb"}, feat_bram_addrb, 0);
   endtask

   task automatic do_write(input int ch, input int baddr, input logic [31:0] data);
      int word;
      bit hit;
      chk("wr_ready_load", wr_ready, 1);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = (ADDR_W+2)'(baddr); wr_data = data;
      tick();
      wr_en = 1'b0;
      word = baddr >> 2;
      hit = 1'b0;
      if (ch < NUM_CH)
         hit = (word < m_depth[ch]);
      if (hit) begin
         m_cnt[ch]++;
         m_ck[ch] += data;
      end else begin
         m_err[1] = 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++)
         if (m_cnt[c] >= m_depth[c]) m_done[c] = 1'b1;
      chk("bram_wea", bram_wea, hit ? (3'b001 << ch) : 3'b000);
      chk("bram_ena", bram_ena, hit ? (3'b001 << ch) : 3'b000);
      if (hit) begin
         chk("bram_addra", bram_addra[ch*ADDR_W +: ADDR_W], word);
         chk("bram_din", bram_din, data);
`ifdef GAT_BRIDGE_CKSUM_EN
         chk("cksum", cksum[ch*32 +: 32], m_ck[ch]);
`endif
      end
      chk("load_done", load_done, m_done);
      chk("err", err, m_err);
      chk("state_load", state, LOAD);
   endtask

   task automatic oob_write();
      int ch;
      if ($urandom_range(0, 1) == 1) begin
         do_write(3, $urandom_range(0, 255), $urandom);
      end else begin
         ch = $urandom_range(0, NUM_CH-1);
         do_write(ch, (m_depth[ch] + $urandom_range(0, 4)) << 2, $urandom);
      end
   endtask

   task automatic load_phase(input bit directed_oob, input int n_oob);
      int j, t, n, oob_left;
      ops_ch.delete();
      ops_w.delete();
      for (int c = 0; c < NUM_CH; c++)
         for (int w = 0; w < m_depth[c]; w++) begin
            ops_ch.push_back(c);
            ops_w.push_back(w);
         end
      n = ops_ch.size();
      for (int i = n - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = ops_ch[i]; ops_ch[i] = ops_ch[j]; ops_ch[j] = t;
         t = ops_w[i];  ops_w[i]  = ops_w[j];  ops_w[j]  = t;
      end
      oob_left = n_oob;
      for (int i = 0; i < n; i++) begin
         do_write(ops_ch[i], (ops_w[i] << 2) | $urandom_range(0, 3), $urandom);
         if (i == 0) begin
            cfg_depth = (NUM_CH*CNT_W)'({$urandom, $urandom});
            if (directed_oob) begin
               do_write(1, 'h10, $urandom);
               chk("err_oob_only", err, 3'b010);
            end
         end
         if ((i < n - 1) && (oob_left > 0) && ($urandom_range(0, 2) == 0)) begin
            oob_write();
            oob_left--;
         end
      end
      chk("all_loaded", load_done, 3'b111);
   endtask

   task automatic arm_to_busy();
      tick();
      chk("state_arm", state, ARM);
      chk("core_start_arm", core_start, 0);
      chk("wr_ready_arm", wr_ready, 0);
      tick();
      chk("state_busy", state, BUSY);
      chk("core_start_pulse", core_start, 1);
      tick();
      chk("core_start_end", core_start, 0);
      chk("state_busy_hold", state, BUSY);
   endtask

   task automatic issue_read(input int baddr, input bit in_done);
      rd_req = 1'b1; rd_addr = (FEAT_ADDR_W+2)'(baddr);
      tick();
      rd_req = 1'b0;
      exp_rd[cyc + RD_LAT + 1] = in_done ? feat_mem[(baddr >> 2) & 255] : 32'h0;
      if (in_done) begin
         chk("feat_bram_addrb", feat_bram_addrb, baddr >> 2);
      end else begin
         m_err[2] = 1'b1;
         chk("err_rd_busy", err, m_err);
      end
   endtask

   task automatic to_done();
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      chk("state_done", state, DONE);
      chk("wr_ready_done", wr_ready, 1);
   endtask

   task automatic busy_write();
      chk("wr_ready_busy", wr_ready, 0);
      wr_en = 1'b1; wr_ch = 2'($urandom_range(0, 2)); wr_addr = '0; wr_data = $urandom;
      tick();
      wr_en = 1'b0;
      m_err[0] = 1'b1;
      chk("err_wr_busy", err, m_err);
      chk("bram_wea_busy", bram_wea, 0);
      chk("state_busy_wr", state, BUSY);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int zc, nc;
      for (int i = 0; i < 256; i++)
         feat_mem[i] = $urandom;
      feat_mem[3] = 32'hDEADBEEF;
      model_clear();
      m_err = '0;

      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
      chk("wr_ready_idle", wr_ready, 1);
      chk("state_idle", state, IDLE);

      // First layer: depths 4/2/3, shuffled in-range writes plus the ch1 word-4 drop.
      set_depths(4, 2, 3);
      load_phase(1'b1, 0);
      arm_to_busy();
      busy_write();
      issue_read($urandom_range(0, 1023), 1'b0);
      tick();
      tick();
      to_done();
      issue_read('h0C, 1'b1);
      for (int i = 0; i < 12; i++)
         issue_read($urandom_range(0, 1023), 1'b1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_err = '0;
      model_clear();
      chk("state_clear", state, IDLE);
      chk("err_clear", err, 0);
      chk("load_done_clear", load_done, 0);
      chk("wr_ready_clear", wr_ready, 1);
      for (int i = 0; i < 4; i++)
         tick();

      // Second layer: random depths with one empty channel and stray writes.
      zc = $urandom_range(0, 2);
      set_depths((zc == 0) ? 0 : $urandom_range(1, 5),
                 (zc == 1) ? 0 : $urandom_range(1, 5),
                 (zc == 2) ? 0 : $urandom_range(1, 5));
      load_phase(1'b0, 3);
      arm_to_busy();
      tick();
      to_done();
      for (int i = 0; i < 6; i++)
         issue_read($urandom_range(0, 1023), 1'b1);
      nc = (zc + 1) % NUM_CH;
      model_clear();
      do_write(nc, 0, $urandom);

      // Reset with a read still in flight discards it.
      issue_read($urandom_range(0, 1023), 1'b0);
      rst = 1'b1;
      #1;
      exp_rd.delete();
      m_err = '0;
      model_clear();
      check_reset_outputs("midreset");
      tick();
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("state_after_reset", state, IDLE);
      chk("wr_ready_after_reset", wr_ready, 1);
      chk("load_done_after_reset", load_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
